muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the mult/div resource and the HI/LO pair of the multicycle MIPS core. The main control FSM pulses start with operands from the A/B registers. The block runs a 32-iteration signed shift-add multiply or a restoring divide, then writes HI/LO and pulses done. While busy is high, the control FSM stalls; it samples div_zero to raise the divide-by-zero exception.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH; HI/LO are each WIDTH bits.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = MULT, 1 = DIV; sampled with start
a  input  WIDTH  operand rs (multiplicand / dividend), signed two's complement
b  input  WIDTH  operand rt (multiplier / divisor), signed two's complement
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse
div_zero  output  1  one-cycle pulse, concurrent with done, on DIV with b == 0
hi  output  WIDTH  HI register: MULT product[63:32] / DIV remainder
lo  output  WIDTH  LO register: MULT product[31:0] / DIV quotient

Behaviour:
- Reset (asynchronous, any state): state = IDLE; busy = done = div_zero = 0; hi = lo = 0; iteration counter = 0; internal operand, accumulator and sign registers cleared.
- States: IDLE, RUN, FIX, FIN.
- IDLE:
  - On an edge with start = 1, latch op, |a|, |b| and the sign bits of a and b (edge E0).
  - DIV with b == 0: go to FIN and set the div_zero flag. hi/lo are unchanged.
  - Otherwise: go to RUN, counter = 0, busy = 1.
  - start = 0 keeps the block in IDLE.
- RUN: one iteration per cycle; counter increments; leave for FIX after counter reaches WIDTH-1, i.e. exactly WIDTH iterations (edges E1..E32).
  - MULT: unsigned shift-add on magnitudes into a 2*WIDTH accumulator.
  - DIV: restoring division on magnitudes. Shift remainder left, subtract divisor, restore if the result is negative; the quotient bit is set when no restore occurs.
- FIX (one cycle, edge E33):
  - MULT: negate the 64-bit product if sign(a) XOR sign(b).
  - DIV: negate the quotient if sign(a) XOR sign(b); negate the remainder if sign(a) = 1 (truncation toward zero, remainder takes the dividend's sign).
  - Write hi/lo on this edge. Go to FIN, busy = 0, done = 1.
- FIN: done (and div_zero if flagged) high for exactly this one cycle. Next edge returns to IDLE and clears done and div_zero. start is ignored in FIN.
- Latency: start sampled at E0 → hi/lo valid and done = 1 in the cycle after E33 (34 cycles). Divide-by-zero: done = div_zero = 1 in the cycle after E0.
- busy: high in RUN and FIX; low in IDLE and FIN.
- start while busy or in FIN is ignored, and the operation in flight is unaffected. Changes on a, b or op after E0 are ignored.
- hi/lo hold their value at all times except the FIX write edge and reset; no other path modifies them.
- Corner arithmetic:
  - |−2^31| is treated as unsigned 2^31 using the WIDTH-bit magnitude.
  - DIV −2^31 / −1 → lo = 0x80000000, hi = 0 (no exception).
  - MULT result is the exact 64-bit signed product.
- Reset asserted mid-RUN: outputs clear immediately, with no done pulse. After reset releases, the block is in IDLE and accepts start on the next edge.

Test Plan:
- Reset, then MULT a=7, b=−3 → busy high for 33 cycles; done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; div_zero=0.
- MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000; then MULT a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIV a=100, b=7 → lo=14, hi=2; DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- DIV a=5, b=0 with hi/lo preloaded from a prior MULT → done=div_zero=1 in the cycle after start; busy never rises; hi/lo unchanged.
- Pulse start again at cycle 10 of a running MULT with different operands → ignored; original result written; exactly one done pulse.
- Assert reset at cycle 15 of a DIV → busy, hi, lo immediately 0; no done. After release, start MULT 3×4 → lo=12, hi=0 at the normal latency.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed multiply / restoring divide with HI/LO result registers.
// Arithmetic runs on operand magnitudes; the sign is applied in a single fix-up cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;

    state_t               state, next;
    logic                 op_r, sa, sb, dz;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     opnd, abs_a, abs_b, fix_hi, fix_lo;
    logic [2*WIDTH-1:0]   acc, step, neg_acc;
    logic [WIDTH:0]       mul_sum, rem_sh, diff;

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // acc holds {partial product, multiplier} for MULT and {remainder, dividend/quotient} for DIV
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : {WIDTH{1'b0}}};
    assign rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign diff    = rem_sh - {1'b0, opnd};
    assign step    = op_r ? {diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~diff[WIDTH]}
                          : {mul_sum, acc[WIDTH-1:1]};

    assign neg_acc = -acc;
    assign fix_hi  = op_r ? (sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                          : ((sa ^ sb) ? neg_acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);
    assign fix_lo  = op_r ? ((sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])
                          : ((sa ^ sb) ? neg_acc[WIDTH-1:0] : acc[WIDTH-1:0]);

    assign busy     = (state == RUN) || (state == FIX);
    assign done     = (state == FIN);
    assign div_zero = (state == FIN) && dz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (start) next = (op && b == '0) ? FIN : RUN;
            RUN:     if (cnt == CW'(WIDTH - 1)) next = FIX;
            FIX:     next = FIN;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r <= 1'b0;
            sa   <= 1'b0;
            sb   <= 1'b0;
            dz   <= 1'b0;
            cnt  <= '0;
            opnd <= '0;
            acc  <= '0;
            hi   <= '0;
            lo   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r <= op;
                    sa   <= a[WIDTH-1];
                    sb   <= b[WIDTH-1];
                    dz   <= op && b == '0;
                    cnt  <= '0;
                    opnd <= op ? abs_b : abs_a;
                    acc  <= {{WIDTH{1'b0}}, op ? abs_a : abs_b};
                end
                RUN: begin
                    acc <= step;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: dz <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed MULT/DIV vectors with hand-computed results and latencies.
module tb_muldiv_sequencer;
    logic        clk = 0, reset = 1, start = 0, op = 0;
    logic [31:0] a = 0, b = 0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;
    int          checks = 0, errors = 0;
    int          lat, busy_cyc, extra_done;
    logic        dz_seen;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op and wait for done; optionally pulse a stray start with other operands at cycle glitch.
    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input int glitch);
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        lat = 0; busy_cyc = 0; dz_seen = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
            if (lat == glitch) begin
                start = 1; op = ~o; a = 32'd1000; b = 32'd3;
            end else begin
                start = 0; a = 32'h5a5a5a5a; b = 32'h0;
            end
            if (done) begin
                dz_seen = div_zero;
                break;
            end
        end
        start = 0;
        if (lat >= 100) chk("timeout", 1, 0);
    endtask

    task automatic watch_done(input int n);
        extra_done = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 0;

        run_op(0, 32'd7, -32'sd3, -1);
        chk("m1_lat", lat, 34);
        chk("m1_busy", busy_cyc, 33);
        chk("m1_hi", hi, 32'hFFFFFFFF);
        chk("m1_lo", lo, 32'hFFFFFFEB);
        chk("m1_dz", dz_seen, 0);
        @(negedge clk);
        chk("m1_done_1cyc", done, 0);

        run_op(0, 32'h80000000, 32'h80000000, -1);
        chk("m2_hi", hi, 32'h40000000);
        chk("m2_lo", lo, 32'h0);
        run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        chk("m3_hi", hi, 32'h0);
        chk("m3_lo", lo, 32'h1);

        run_op(1, -32'sd7, 32'd2, -1);
        chk("d1_lat", lat, 34);
        chk("d1_lo", lo, 32'hFFFFFFFD);
        chk("d1_hi", hi, 32'hFFFFFFFF);
        run_op(1, 32'd100, 32'd7, -1);
        chk("d2_lo", lo, 32'd14);
        chk("d2_hi", hi, 32'd2);
        run_op(1, 32'h80000000, 32'hFFFFFFFF, -1);
        chk("d3_lo", lo, 32'h80000000);
        chk("d3_hi", hi, 32'h0);
        chk("d3_dz", dz_seen, 0);

        run_op(0, 32'h00010000, 32'h00030005, -1);
        chk("pre_hi", hi, 32'd3);
        chk("pre_lo", lo, 32'h00050000);
        run_op(1, 32'd5, 32'd0, -1);
        chk("dz_lat", lat, 1);
        chk("dz_flag", dz_seen, 1);
        chk("dz_busy", busy_cyc, 0);
        chk("dz_hi", hi, 32'd3);
        chk("dz_lo", lo, 32'h00050000);
        @(negedge clk);
        chk("dz_clr_done", done, 0);
        chk("dz_clr_flag", div_zero, 0);

        run_op(0, 32'd6, 32'd7, 10);
        chk("g_lat", lat, 34);
        chk("g_lo", lo, 32'd42);
        chk("g_hi", hi, 32'd0);
        watch_done(40);
        chk("g_one_done", extra_done, 0);

        @(negedge clk);
        start = 1; op = 1; a = 32'd1000; b = 32'd7;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start = 0;
        end
        chk("r_busy_pre", busy, 1);
        reset = 1;
        #1;
        chk("r_busy", busy, 0);
        chk("r_hi", hi, 0);
        chk("r_lo", lo, 0);
        chk("r_done", done, 0);
        @(negedge clk);
        reset = 0;
        watch_done(30);
        chk("r_no_done", extra_done, 0);
        run_op(0, 32'd3, 32'd4, -1);
        chk("r_lat", lat, 34);
        chk("r_lo2", lo, 32'd12);
        chk("r_hi2", hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
